// File: rtl/pipe_stage_pkg.sv
// Shared ID/EX payload layout and bubble encoding for the pipeline-stage slice.
// Field offsets here must stay in sync with the decoder that packs the payload.
package pipe_stage_pkg;

    localparam int ALUOP_W   = 8;
    localparam int ALUSEL_W  = 3;
    localparam int REGADDR_W = 5;

    localparam int ALUOP_LSB  = 0;
    localparam int ALUSEL_LSB = ALUOP_LSB + ALUOP_W;
    localparam int REG1_LSB   = ALUSEL_LSB + ALUSEL_W;
    localparam int REG2_LSB   = REG1_LSB + REGADDR_W;
    localparam int WD_LSB     = REG2_LSB + REGADDR_W;
    localparam int WREG_LSB   = WD_LSB + REGADDR_W;
    localparam int PAYLOAD_W  = 32;

    localparam logic [ALUOP_W-1:0]   EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUSEL_W-1:0]  EXE_RES_NOP = 3'b000;
    localparam logic [REGADDR_W-1:0] NOPRegAddr  = 5'b00000;

    typedef struct packed {
        logic [PAYLOAD_W-WREG_LSB-2:0] pad;
        logic                          wreg;
        logic [REGADDR_W-1:0]          wd;
        logic [REGADDR_W-1:0]          reg2Addr;
        logic [REGADDR_W-1:0]          reg1Addr;
        logic [ALUSEL_W-1:0]           alusel;
        logic [ALUOP_W-1:0]            aluop;
    } idExPayload_t;

    // A bubble is a no-op that reads nothing and writes no register.
    localparam logic [PAYLOAD_W-1:0] NOP_VAL_DEFAULT =
        {5'b00000, 1'b0, NOPRegAddr, NOPRegAddr, NOPRegAddr, EXE_RES_NOP, EXE_NOP_OP};

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage slot of the stage: a valid bit plus payload, refilled with the
// bubble encoding whenever it is cleared or reset.
module pipe_slot #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clear wins over load so a flush can never let a payload slip through.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Skid-buffered pipeline register with flush and a saturating stall counter.
// in_ready comes straight from the skid flop, so out_ready never reaches it.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_VAL_DEFAULT),
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              mainValid, skidValid;
    logic [DATA_W-1:0] mainData, skidData;
    logic              mainAdvance, inXfer;
    logic              mainClear, mainLoad, skidClear, skidLoad;
    logic [DATA_W-1:0] mainLoadData;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    assign in_ready    = ~skidValid;
    assign inXfer      = in_valid & in_ready;
    assign mainAdvance = ~mainValid | out_ready;

    // The skid entry is older than anything arriving now, so it refills main first.
    always_comb begin
        mainClear    = flush | (mainAdvance & ~skidValid & ~inXfer);
        mainLoad     = ~flush & mainAdvance & (skidValid | inXfer);
        mainLoadData = skidValid ? skidData : in_data;
        skidClear    = flush | (mainAdvance & skidValid);
        skidLoad     = ~flush & ~mainAdvance & inXfer;
    end

    pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) uMainSlot (
        .clk     (clk),
        .rst     (rst),
        .clear_i (mainClear),
        .load_i  (mainLoad),
        .data_i  (mainLoadData),
        .valid_o (mainValid),
        .data_o  (mainData)
    );

    pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) uSkidSlot (
        .clk     (clk),
        .rst     (rst),
        .clear_i (skidClear),
        .load_i  (skidLoad),
        .data_i  (in_data),
        .valid_o (skidValid),
        .data_o  (skidData)
    );

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mainValid && !out_ready && !flush && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed and random checks of pipe_stage against a queue-based model of
// the stage's occupancy (at most two entries in flight, oldest drives out).
module tb_pipe_stage;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [3:0] stall_cnt;

    int compared = 0;
    int failed   = 0;

    logic [7:0] modelQ[$];
    int         modelStall = 0;

    pipe_stage #(.DATA_W(8), .NOP_VAL(8'h00), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the
    // rising edge, and return at the next falling edge for sampling.
    task automatic applyStimulus(input bit rs, input bit fl, input bit iv,
                                 input logic [7:0] id, input bit ordy);
        bit doPop, doPush;
        rst       = rs;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        if (rs) begin
            modelQ.delete();
            modelStall = 0;
        end else if (fl) begin
            modelQ.delete();
        end else begin
            doPop  = (modelQ.size() > 0) && ordy;
            doPush = iv && (modelQ.size() < 2);
            if ((modelQ.size() > 0) && !ordy && (modelStall < 15)) modelStall++;
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(id);
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] expData;
        expData = (modelQ.size() > 0) ? modelQ[0] : 8'h00;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(modelQ.size() > 0));
        check({tag, ".out_data"},  32'(out_data),  32'(expData));
        check({tag, ".in_ready"},  32'(in_ready),  32'(modelQ.size() < 2));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(modelStall));
    endtask

    initial begin
        logic [7:0] prevData;
        bit         prevHold;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1, 0, 1, 8'hEE, 0);
        applyStimulus(1, 0, 1, 8'hEF, 1);
        checkOutput("reset");
        check("reset.out_data_const", 32'(out_data), 32'h00);
        check("reset.in_ready_const", 32'(in_ready), 32'h1);

        // Streaming with the consumer always ready
        applyStimulus(0, 0, 1, 8'h11, 1);
        checkOutput("stream11");
        check("stream11.const", 32'(out_data), 32'h11);
        applyStimulus(0, 0, 1, 8'h22, 1);
        checkOutput("stream22");
        check("stream22.const", 32'(out_data), 32'h22);
        applyStimulus(0, 0, 1, 8'h33, 1);
        checkOutput("stream33");
        check("stream33.const", 32'(out_data), 32'h33);
        check("stream33.in_ready", 32'(in_ready), 32'h1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("streamDrain");

        // Back-pressure fills main then skid
        applyStimulus(0, 0, 1, 8'hA1, 0);
        checkOutput("bpA1");
        applyStimulus(0, 0, 1, 8'hA2, 0);
        checkOutput("bpA2");
        check("bpFull.out_data", 32'(out_data), 32'hA1);
        check("bpFull.in_ready", 32'(in_ready), 32'h0);
        applyStimulus(0, 0, 1, 8'hA3, 0);
        checkOutput("bpBlocked");
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("bpDrain1");
        check("bpDrain1.out_data", 32'(out_data), 32'hA2);
        check("bpDrain1.in_ready", 32'(in_ready), 32'h1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("bpDrain2");

        // Flush with both slots full and a concurrent input
        applyStimulus(0, 0, 1, 8'hB1, 0);
        applyStimulus(0, 0, 1, 8'hB2, 0);
        checkOutput("flushPre");
        applyStimulus(0, 1, 1, 8'hFF, 0);
        checkOutput("flush");
        check("flush.out_valid", 32'(out_valid), 32'h0);
        check("flush.out_data",  32'(out_data),  32'h00);
        check("flush.in_ready",  32'(in_ready),  32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1);
            check("flush.noFF", 32'(out_data != 8'hFF), 32'h1);
            checkOutput("flushIdle");
        end

        // Long stall saturates the counter while data holds
        applyStimulus(0, 0, 1, 8'h77, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            check("stall.hold", 32'(out_data), 32'h77);
            checkOutput("stall");
        end
        check("stall.sat", 32'(stall_cnt), 32'hF);

        // Reset mid-stream with the skid full
        applyStimulus(0, 0, 1, 8'h78, 0);
        checkOutput("rstPre");
        applyStimulus(1, 0, 1, 8'h99, 0);
        checkOutput("rstMid");
        check("rstMid.out_valid", 32'(out_valid), 32'h0);
        check("rstMid.stall_cnt", 32'(stall_cnt), 32'h0);
        applyStimulus(0, 0, 1, 8'h5A, 1);
        checkOutput("post5A");
        check("post5A.const", 32'(out_data), 32'h5A);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("postIdle");

        // Random traffic; stability is also checked directly against the last sample
        prevHold = 1'b0;
        prevData = '0;
        for (int i = 0; i < 10000; i++) begin
            bit rs, fl, iv, ordy;
            logic [7:0] id;
            rs   = ($urandom_range(0, 499) == 0);
            fl   = ($urandom_range(0, 63) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            id   = 8'($urandom);
            prevHold = (modelQ.size() > 0) && !ordy && !fl && !rs;
            prevData = (modelQ.size() > 0) ? modelQ[0] : 8'h00;
            applyStimulus(rs, fl, iv, id, ordy);
            checkOutput("rand");
            if (prevHold) begin
                check("rand.stable", 32'(out_data), 32'(prevData));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32; payload width in bits (carries packed aluop/alusel/reg1/reg2/wd/wreg).
REQ-002 Parameter NOP_VAL, default 0; DATA_W-bit payload driven whenever the stage holds no valid entry (bubble encoding).
REQ-003 Parameter CNT_W, default 16; stall-counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all held and incoming entries this cycle.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept; registered.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream payload valid; registered.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_data  output  DATA_W  downstream payload; registered.
REQ-013 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-014 Two storage slots: main (drives out_*) and skid; each holds valid bit plus DATA_W payload.
REQ-015 Input transfer occurs when in_valid and in_ready are both 1 on a rising edge; output transfer when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal the registered inverse of skid valid; it never depends combinationally on out_ready.
REQ-017 Main advances when main is empty or out_ready=1.
REQ-018 On advance: main loads skid if skid valid (skid cleared); else main loads in_data if an input transfer occurs; else main becomes empty.
REQ-019 On no advance with an input transfer: skid loads in_data; next cycle in_ready=0.
REQ-020 Latency: empty stage, input transfer at edge N -> out_valid=1 with that payload after edge N.
REQ-021 Throughput: one transfer per cycle sustained while out_ready=1; no bubbles inserted.
REQ-022 Ordering: entries leave in arrival order; none duplicated or lost except by flush.
REQ-023 While out_valid=1 and out_ready=0, out_valid and out_data SHALL hold stable.
REQ-024 Whenever main is empty, out_data SHALL equal NOP_VAL.
REQ-025 flush=1 has priority over all transfers: both slots emptied, out_data<=NOP_VAL, concurrent input discarded, in_ready=1 next cycle.
REQ-026 flush does not alter stall_cnt.
REQ-027 stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0 and flush=0; saturates at all-ones; no wrap.

Reset
REQ-028 While rst=1 at an edge: main and skid empty, out_valid=0, out_data=NOP_VAL, in_ready=1, stall_cnt=0.
REQ-029 rst overrides flush and all transfers; in_valid during reset cycles is ignored, including mid-stream entries which are dropped.
REQ-030 First transfer possible on the first edge with rst=0.

Structure
REQ-031 NOP_VAL default and payload field offsets/widths (aluop, alusel, reg, regaddr) SHALL live in the shared define/package, alongside EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr.
REQ-032 One sub-module pipe_slot (valid + DATA_W register with load, clear, NOP fill) SHALL be instantiated twice (main, skid).
REQ-033 No latches; no combinational path from out_ready to in_ready.

Verification (DATA_W=8, NOP_VAL=8'h00, CNT_W=4)
REQ-034 Reset then stream 8'h11,8'h22,8'h33 with out_ready=1 -> out_data 11,22,33 on consecutive cycles, one cycle after each input; in_ready stays 1.
REQ-035 out_ready=0 while 8'hA1,8'hA2 sent -> main=A1, skid=A2, in_ready=0; out_ready=1 -> A1 then A2 output, in_ready=1 one cycle after skid drains.
REQ-036 Both slots full, flush=1 with in_valid=1 in_data=8'hFF -> next cycle out_valid=0, out_data=00, in_ready=1; FF never appears at output.
REQ-037 out_valid=1, out_ready=0 held 20 cycles -> stall_cnt reaches 4'hF and holds; out_data unchanged throughout.
REQ-038 rst asserted with skid full mid-stream -> next cycle out_valid=0, out_data=00, stall_cnt=0, in_ready=1; subsequent 8'h5A passes with 1-cycle latency.
REQ-039 Random in_valid/out_ready/flush for 10k cycles -> scoreboard confirms order, no loss outside flush/reset, stability rule REQ-023 holds.
